dmem_bytelane_ctrl: RTL and testbench
=====================================

Name: dmem_bytelane_ctrl

Overview:
- Parametrised successor to the core's word-only data memory: byte-lane RAM for loads and stores of byte, halfword and word size.
- Loads are sign- or zero-extended; reads are registered (1-cycle latency) behind a REQ/READY handshake.
- Misaligned or illegal accesses are detected and flagged.
- A post-reset clear sequencer zeroes the whole array in hardware, so no simulation-only initial blocks are needed.
- Sits between the datapath's ALU result/rs2 and the writeback mux.

Parameters:
- BITS_ADDR, 8, byte-address width; DEPTH = 2**BITS_ADDR/4 words (64 at default).
- CLEAR_ON_RESET, 1, 1 = run the clear sequence after reset; 0 = go straight to IDLE with contents undefined.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  synchronous, active-high reset.
- REQ  input  1  access request; sampled only when READY=1.
- WE  input  1  1 = store, 0 = load; qualified by REQ.
- FUNCT3  input  3  size/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- ADDR  input  BITS_ADDR  byte address.
- WriteData  input  32  store data, right-aligned.
- READY  output  1  1 = request accepted at this edge.
- RVALID  output  1  one-cycle pulse per accepted request.
- ReadData  output  32  extended load data; 0 for stores and errors.
- ERR  output  1  valid with RVALID; misaligned or illegal FUNCT3.

Behaviour:
- Storage: four 8-bit lanes × DEPTH words. Word index = ADDR[BITS_ADDR-1:2]; lane = ADDR[1:0]. Little-endian: lane i holds bits [8i+7:8i].
- FSM states: CLEAR, IDLE.
  - RST=1 at an edge → state CLEAR if CLEAR_ON_RESET=1, else IDLE. Clear counter ← 0. READY, RVALID, ERR ← 0; ReadData ← 0.
  - CLEAR: each edge writes 0 to all lanes of word[counter] and increments counter. The edge that writes word DEPTH-1 moves to IDLE.
  - READY = (state==IDLE). With default DEPTH=64, READY rises after the 64th post-reset edge.
  - RST asserted mid-CLEAR restarts from word 0.
  - REQ while READY=0 is ignored (not queued); the requester holds REQ.
- Accept: edge with REQ=1 and READY=1.
  - Exactly one RVALID=1 on the next cycle. RVALID=0 in every other cycle. Full throughput: one access per cycle.
- Error check on the accepted request:
  - ERR=1 if FUNCT3 ∈ {011,110,111}.
  - ERR=1 if halfword with ADDR[0]=1.
  - ERR=1 if word with ADDR[1:0]≠0.
  - BU/HU with WE=1 are illegal (ERR=1).
  - On error: no array write, ReadData=0.
- Store (WE=1, no error): written at the accept edge.
  - SB: lane ADDR[1:0] ← WriteData[7:0].
  - SH: lanes {ADDR[1],0} and {ADDR[1],1} ← WriteData[15:0].
  - SW: all lanes ← WriteData.
  - Other lanes are untouched. RVALID pulses with ReadData=0, ERR=0.
- Load (WE=0, no error): at the accept edge, ReadData ← word read and extended.
  - B/BU: selected byte, sign/zero-extended to 32 bits.
  - H/HU: selected half, sign/zero-extended.
  - W: whole word.
- Store at edge N followed by a load of the same word at edge N+1 returns the new data; no forwarding logic is required.
- ReadData and ERR hold their value until the next RVALID or reset. The bench checks them only when RVALID=1.
- No X propagation: ReadData is never driven from an unwritten word while CLEAR_ON_RESET=1.

Test Plan:
- Clear sequence (BITS_ADDR=8): pulse RST for 2 cycles, then release → READY=0 for exactly 64 edges, then 1. LW from addresses 0x00, 0x7C and 0xFC all return 0x00000000, ERR=0.
- Byte lanes: SW 0x11223344 @0x10; SB 0xAA @0x12; then LW @0x10 → 0x11AA3344. LB @0x12 → 0xFFFFFFAA. LBU @0x12 → 0x000000AA.
- Halfwords: SH 0x8001 @0x22 → LH @0x22 = 0xFFFF8001, LHU @0x22 = 0x00008001. LW @0x20 has its low half unchanged from the clear value (0x80010000).
- Errors: LW @0x21, LH @0x23, FUNCT3=011, and an SB with WE=1 and FUNCT3=100 → each gives RVALID with ERR=1 and ReadData=0. The target word is unchanged, checked by a subsequent LW.
- Back-to-back: REQ held high for 4 cycles (SW 0xDEADBEEF @0x40, LW @0x40, SB 0x00 @0x43, LW @0x40) → 4 consecutive RVALID pulses. Loads return 0xDEADBEEF, then 0x00ADBEEF.
- Reset mid-clear: assert RST at clear-count 30 for 1 cycle → READY stays 0 for 64 further edges. Meanwhile REQ=1 with a store produces no RVALID and no write.

Source files
------------

// File: rtl/dmem_bytelane_ctrl_if.sv
// Request/response bundle between the datapath and the byte-lane data memory.
// The requester drives the master side; the memory implements the slave side.
interface dmem_bytelane_ctrl_if #(
    parameter int BITS_ADDR = 8
);
    logic                 REQ;
    logic                 WE;
    logic [2:0]           FUNCT3;
    logic [BITS_ADDR-1:0] ADDR;
    logic [31:0]          WriteData;
    logic                 READY;
    logic                 RVALID;
    logic [31:0]          ReadData;
    logic                 ERR;

    modport master (
        output REQ, WE, FUNCT3, ADDR, WriteData,
        input  READY, RVALID, ReadData, ERR
    );

    modport slave (
        input  REQ, WE, FUNCT3, ADDR, WriteData,
        output READY, RVALID, ReadData, ERR
    );
endinterface

// File: rtl/dmem_bytelane_ctrl.sv
// Byte-lane data memory (B/H/W loads+stores, sign/zero extension, hardware clear after reset).
// One access per cycle, RVALID one cycle after accept; REQ is ignored (not queued) while READY=0.
module dmem_bytelane_ctrl #(
    parameter int BITS_ADDR      = 8,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                 CLK,
    input  logic                 RST,
    dmem_bytelane_ctrl_if.slave  bus
);
    localparam int IW    = BITS_ADDR - 2;
    localparam int DEPTH = 2**IW;

    typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   cnt_q, cnt_d;
    logic            rvalid_q, rvalid_d;
    logic            err_q, err_d;
    logic [31:0]     rdata_q, rdata_d;

    logic [3:0][7:0] mem_q [DEPTH];

    logic [IW-1:0]   widx, mem_idx;
    logic [1:0]      lane;
    logic            accept, bad, clr;
    logic [3:0]      st_be, mem_be;
    logic [3:0][7:0] st_wdat, mem_wdat;
    logic [31:0]     rd_word, ld_data;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;

    assign widx   = bus.ADDR[BITS_ADDR-1:2];
    assign lane   = bus.ADDR[1:0];
    assign accept = bus.REQ && (state_q == ST_IDLE) && !RST;
    assign clr    = (state_q == ST_CLEAR) && !RST;

    // Unsigned loads cannot be stores; halfwords need even, words need 4-aligned addresses.
    always_comb begin
        bad = 1'b0;
        case (bus.FUNCT3)
            3'b000:  bad = 1'b0;
            3'b001:  bad = bus.ADDR[0];
            3'b010:  bad = |bus.ADDR[1:0];
            3'b100:  bad = bus.WE;
            3'b101:  bad = bus.WE | bus.ADDR[0];
            default: bad = 1'b1;
        endcase
    end

    always_comb begin
        st_be   = '0;
        st_wdat = {4{bus.WriteData[7:0]}};
        case (bus.FUNCT3[1:0])
            2'b00: st_be = 4'b0001 << lane;
            2'b01: begin
                st_be   = bus.ADDR[1] ? 4'b1100 : 4'b0011;
                st_wdat = {2{bus.WriteData[15:0]}};
            end
            2'b10: begin
                st_be   = 4'b1111;
                st_wdat = bus.WriteData;
            end
            default: st_be = '0;
        endcase
    end

    assign rd_word = mem_q[widx];
    assign ld_byte = rd_word[{lane, 3'b000} +: 8];
    assign ld_half = bus.ADDR[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        ld_data = '0;
        case (bus.FUNCT3)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_data = {24'h0, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_data = {16'h0, ld_half};
            3'b010:  ld_data = rd_word;
            default: ld_data = '0;
        endcase
    end

    // The clear sequencer owns the single write port while it runs.
    always_comb begin
        mem_idx  = widx;
        mem_be   = '0;
        mem_wdat = st_wdat;
        if (clr) begin
            mem_idx  = cnt_q;
            mem_be   = 4'b1111;
            mem_wdat = '0;
        end else if (accept && bus.WE && !bad) begin
            mem_be = st_be;
        end
    end

    always_ff @(posedge CLK) begin
        for (int l = 0; l < 4; l++) begin
            if (mem_be[l]) begin
                mem_q[mem_idx][l] <= mem_wdat[l];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rvalid_d = accept;
        err_d    = err_q;
        rdata_d  = rdata_q;
        if (state_q == ST_CLEAR) begin
            cnt_d = cnt_q + 1'b1;
            if (&cnt_q) begin
                state_d = ST_IDLE;
            end
        end
        if (accept) begin
            err_d   = bad;
            rdata_d = (bad || bus.WE) ? 32'h0 : ld_data;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
            cnt_q    <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
        end
    end

    assign bus.READY    = (state_q == ST_IDLE);
    assign bus.RVALID   = rvalid_q;
    assign bus.ReadData = rdata_q;
    assign bus.ERR      = err_q;
endmodule

// File: tb/tb_dmem_bytelane_ctrl.sv
// Bench for dmem_bytelane_ctrl: directed table, hand sequences for clear/back-to-back/reset,
// and random accesses against a byte-addressed reference memory.
module tb_dmem_bytelane_ctrl;
    localparam int BA = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dmem_bytelane_ctrl_if #(.BITS_ADDR(BA)) bus ();

    dmem_bytelane_ctrl #(.BITS_ADDR(BA), .CLEAR_ON_RESET(1'b1)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus.slave)
    );

    int n_vec = 0;
    int n_bad = 0;
    logic [7:0] ref_mem [256];

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [7:0]  addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t tbl [18];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Byte-granular model: applies stores and returns the expected response.
    function automatic void model(input logic we, input logic [2:0] f3, input logic [7:0] addr,
                                  input logic [31:0] wd, output logic [31:0] rd, output logic err);
        int nbytes;
        longint lv;
        rd  = '0;
        err = 1'b0;
        nbytes = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) err = 1'b1;
        else if ((int'(addr) % nbytes) != 0)       err = 1'b1;
        else if (we && f3[2])                       err = 1'b1;
        if (err) return;
        if (we) begin
            for (int k = 0; k < nbytes; k++) ref_mem[int'(addr) + k] = wd[8*k +: 8];
        end else begin
            lv = 0;
            for (int k = 0; k < nbytes; k++) lv += longint'(ref_mem[int'(addr) + k]) << (8*k);
            if (!f3[2] && nbytes < 4 && lv >= (64'd1 << (8*nbytes - 1)))
                lv -= (64'd1 << (8*nbytes));
            rd = lv[31:0];
        end
    endfunction

    task automatic access(input logic we, input logic [2:0] f3, input logic [7:0] addr,
                          input logic [31:0] wd, output logic [31:0] rd, output logic err,
                          output logic rv);
        int budget = 0;
        bus.REQ = 1'b1; bus.WE = we; bus.FUNCT3 = f3; bus.ADDR = addr; bus.WriteData = wd;
        while (!bus.READY && budget < 200) begin
            @(posedge clk); #1;
            budget++;
        end
        if (!bus.READY) begin
            chk("ready_timeout", 32'd0, 32'd1);
            bus.REQ = 1'b0;
            rd = '0; err = 1'b0; rv = 1'b0;
        end else begin
            @(posedge clk); #1;
            bus.REQ = 1'b0;
            rv  = bus.RVALID;
            rd  = bus.ReadData;
            err = bus.ERR;
        end
    endtask

    task automatic apply(input string nm, input logic we, input logic [2:0] f3,
                         input logic [7:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic exp_err);
        logic [31:0] rd;
        logic err, rv;
        access(we, f3, addr, wd, rd, err, rv);
        chk({nm, "_rvalid"}, {31'd0, rv}, 32'd1);
        chk({nm, "_rdata"}, rd, exp_rd);
        chk({nm, "_err"}, {31'd0, err}, {31'd0, exp_err});
    endtask

    task automatic count_clear(output int n, output int rv_seen);
        n = 0;
        rv_seen = 0;
        while (!bus.READY && n < 200) begin
            @(posedge clk); #1;
            n++;
            if (bus.RVALID) rv_seen++;
            if (bus.READY) bus.REQ = 1'b0;
        end
    endtask

    initial begin
        int n, rv_seen;
        logic [31:0] erd;
        logic eerr, we;
        logic [2:0] f3;
        logic [7:0] addr;
        logic [31:0] wd;
        int nb;

        tbl[0]  = '{1'b1, 3'b010, 8'h10, 32'h11223344, 32'h00000000, 1'b0};
        tbl[1]  = '{1'b1, 3'b000, 8'h12, 32'h000000AA, 32'h00000000, 1'b0};
        tbl[2]  = '{1'b0, 3'b010, 8'h10, 32'h0,        32'h11AA3344, 1'b0};
        tbl[3]  = '{1'b0, 3'b000, 8'h12, 32'h0,        32'hFFFFFFAA, 1'b0};
        tbl[4]  = '{1'b0, 3'b100, 8'h12, 32'h0,        32'h000000AA, 1'b0};
        tbl[5]  = '{1'b1, 3'b001, 8'h22, 32'h00008001, 32'h00000000, 1'b0};
        tbl[6]  = '{1'b0, 3'b001, 8'h22, 32'h0,        32'hFFFF8001, 1'b0};
        tbl[7]  = '{1'b0, 3'b101, 8'h22, 32'h0,        32'h00008001, 1'b0};
        tbl[8]  = '{1'b0, 3'b010, 8'h20, 32'h0,        32'h80010000, 1'b0};
        tbl[9]  = '{1'b0, 3'b010, 8'h21, 32'h0,        32'h00000000, 1'b1};
        tbl[10] = '{1'b0, 3'b001, 8'h23, 32'h0,        32'h00000000, 1'b1};
        tbl[11] = '{1'b0, 3'b011, 8'h10, 32'h0,        32'h00000000, 1'b1};
        tbl[12] = '{1'b1, 3'b100, 8'h10, 32'h00000055, 32'h00000000, 1'b1};
        tbl[13] = '{1'b1, 3'b001, 8'h21, 32'h0000FFFF, 32'h00000000, 1'b1};
        tbl[14] = '{1'b1, 3'b010, 8'h12, 32'hFFFFFFFF, 32'h00000000, 1'b1};
        tbl[15] = '{1'b0, 3'b110, 8'h10, 32'h0,        32'h00000000, 1'b1};
        tbl[16] = '{1'b0, 3'b010, 8'h10, 32'h0,        32'h11AA3344, 1'b0};
        tbl[17] = '{1'b0, 3'b010, 8'h20, 32'h0,        32'h80010000, 1'b0};

        rst = 1'b1;
        bus.REQ = 1'b0; bus.WE = 1'b0; bus.FUNCT3 = '0; bus.ADDR = '0; bus.WriteData = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready",  {31'd0, bus.READY},  32'd0);
        chk("rst_rvalid", {31'd0, bus.RVALID}, 32'd0);
        chk("rst_err",    {31'd0, bus.ERR},    32'd0);
        chk("rst_rdata",  bus.ReadData,        32'd0);
        rst = 1'b0;
        count_clear(n, rv_seen);
        chk("clear_edges", n, 32'd64);

        apply("clr_lw00", 1'b0, 3'b010, 8'h00, 32'h0, 32'h0, 1'b0);
        apply("clr_lw7c", 1'b0, 3'b010, 8'h7C, 32'h0, 32'h0, 1'b0);
        apply("clr_lwfc", 1'b0, 3'b010, 8'hFC, 32'h0, 32'h0, 1'b0);

        for (int i = 0; i < 18; i++) begin
            model(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wd, erd, eerr);
            apply($sformatf("vec%0d", i), tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wd,
                  tbl[i].exp_rd, tbl[i].exp_err);
        end

        // Back-to-back: each apply checks RVALID in the cycle straight after the previous one.
        model(1'b1, 3'b010, 8'h40, 32'hDEADBEEF, erd, eerr);
        apply("b2b_sw", 1'b1, 3'b010, 8'h40, 32'hDEADBEEF, 32'h0, 1'b0);
        apply("b2b_lw1", 1'b0, 3'b010, 8'h40, 32'h0, 32'hDEADBEEF, 1'b0);
        model(1'b1, 3'b000, 8'h43, 32'h00000000, erd, eerr);
        apply("b2b_sb", 1'b1, 3'b000, 8'h43, 32'h00000000, 32'h0, 1'b0);
        apply("b2b_lw2", 1'b0, 3'b010, 8'h40, 32'h0, 32'h00ADBEEF, 1'b0);
        @(posedge clk); #1;
        chk("idle_rvalid", {31'd0, bus.RVALID}, 32'd0);
        chk("hold_rdata", bus.ReadData, 32'h00ADBEEF);

        for (int i = 0; i < 400; i++) begin
            we   = 1'($urandom_range(0, 1));
            f3   = 3'($urandom_range(0, 7));
            addr = 8'($urandom_range(0, 255));
            wd   = $urandom;
            nb   = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
            if ($urandom_range(0, 3) != 0) addr = addr & ~8'(nb - 1);
            model(we, f3, addr, wd, erd, eerr);
            apply($sformatf("rnd%0d", i), we, f3, addr, wd, erd, eerr);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
                chk("rnd_idle_rvalid", {31'd0, bus.RVALID}, 32'd0);
            end
        end

        // Reset part-way through the clear; a held store must be neither accepted nor answered.
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.REQ = 1'b1; bus.WE = 1'b1; bus.FUNCT3 = 3'b010; bus.ADDR = 8'h80;
        bus.WriteData = 32'hCAFEF00D;
        rv_seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (bus.RVALID) rv_seen++;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        count_clear(n, nb);
        chk("midclr_edges", n, 32'd64);
        chk("midclr_no_rvalid", rv_seen + nb, 32'd0);
        @(posedge clk); #1;
        chk("midclr_after_rvalid", {31'd0, bus.RVALID}, 32'd0);
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        apply("midclr_lw80", 1'b0, 3'b010, 8'h80, 32'h0, 32'h0, 1'b0);
        apply("midclr_lw40", 1'b0, 3'b010, 8'h40, 32'h0, 32'h0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
